// File: rtl/mem_access_initiator.sv
// mem_access_initiator: MEM-stage load/store initiator with byte RMW stores and range rejection
module mem_access_initiator #(
  parameter int ADDR_W = 16,
  parameter int MEM_BYTES = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] d_mem_addr,
  output logic              d_mem_opertn,
  output logic              wr_rd,
  output logic [7:0]        d_mem_wr_data_l,
  output logic [7:0]        d_mem_wr_data_h,
  input  logic [7:0]        d_mem_rd_data_l,
  input  logic [7:0]        d_mem_rd_data_h
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;
  state_t state, state_nx;
  logic wr_q, byte_q, signed_q, err_q, accept, range_err, mem_cyc;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0] wdata_q;
  logic [7:0] cap_h;
  assign req_ready = state == IDLE;
  assign busy = !req_ready;
  assign accept = req_valid && req_ready;
  assign range_err = req_addr > ADDR_W'(MEM_BYTES - 2);
  assign resp_valid = state == RESP;
  assign resp_err = resp_valid && err_q;
  assign mem_cyc = state == RD || state == WR;
  assign d_mem_opertn = reset && mem_cyc;
  assign wr_rd = state == WR;
  assign d_mem_addr = mem_cyc ? addr_q : '0;
  assign d_mem_wr_data_l = wr_rd ? wdata_q[7:0] : 8'h00;
  // a byte store writes back the neighbouring byte captured during its read
  assign d_mem_wr_data_h = !wr_rd ? 8'h00 : byte_q ? cap_h : wdata_q[15:8];
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = !accept ? IDLE : range_err ? RESP : (req_wr && !req_byte) ? WR : RD;
      RD:   state_nx = WAIT;
      WAIT: state_nx = (wr_q && byte_q) ? WR : RESP;
      WR:   state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      wr_q <= 1'b0;
      byte_q <= 1'b0;
      signed_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cap_h <= '0;
      resp_rdata <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        wr_q <= req_wr;
        byte_q <= req_byte;
        signed_q <= req_signed;
        err_q <= range_err;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == WAIT) begin
        cap_h <= d_mem_rd_data_h;
        if (!wr_q)
          resp_rdata <= byte_q ? {{8{signed_q && d_mem_rd_data_l[7]}}, d_mem_rd_data_l}
                               : {d_mem_rd_data_h, d_mem_rd_data_l};
      end
    end
  end
endmodule

// File: tb/tb_mem_access_initiator.sv
// tb_mem_access_initiator: table-driven check of mem_access_initiator against a registered-read memory model
module tb_mem_access_initiator;
  logic clk = 0, reset = 0;
  logic req_valid = 0, req_wr = 0, req_byte = 0, req_signed = 0;
  logic [15:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err, busy, d_mem_opertn, wr_rd;
  logic [15:0] resp_rdata, d_mem_addr;
  logic [7:0] d_mem_wr_data_l, d_mem_wr_data_h, d_mem_rd_data_l, d_mem_rd_data_h;
  int checks = 0, errors = 0;

  mem_access_initiator dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_byte(req_byte), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .d_mem_addr(d_mem_addr), .d_mem_opertn(d_mem_opertn), .wr_rd(wr_rd),
    .d_mem_wr_data_l(d_mem_wr_data_l), .d_mem_wr_data_h(d_mem_wr_data_h),
    .d_mem_rd_data_l(d_mem_rd_data_l), .d_mem_rd_data_h(d_mem_rd_data_h)
  );

  always #5 clk = ~clk;

  // memory: registered read, write-data forwarded onto the read bus when idle
  logic [7:0] mem [128];
  logic init_done = 0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h06; mem[1] <= 8'h00; mem[2] <= 8'h01; mem[3] <= 8'h40;
      mem[4] <= 8'h12; mem[5] <= 8'h34; mem[8] <= 8'h84; mem[9] <= 8'h40;
      mem[126] <= 8'hC3; mem[127] <= 8'h11;
      d_mem_rd_data_l <= 8'h00;
      d_mem_rd_data_h <= 8'h00;
      init_done <= 1;
    end else if (d_mem_opertn) begin
      if (d_mem_addr > 16'd126) $display("Memory model: out-of-range access %h", d_mem_addr);
      else if (wr_rd) begin
        mem[d_mem_addr[6:0]] <= d_mem_wr_data_l;
        mem[d_mem_addr[6:0] + 7'd1] <= d_mem_wr_data_h;
      end else begin
        d_mem_rd_data_l <= mem[d_mem_addr[6:0]];
        d_mem_rd_data_h <= mem[d_mem_addr[6:0] + 7'd1];
      end
    end else begin
      d_mem_rd_data_l <= d_mem_wr_data_l;
      d_mem_rd_data_h <= d_mem_wr_data_h;
    end
  end

  typedef struct {
    logic wr, byt, sgn;
    logic [15:0] addr, wdata;
    int lat, ops;
    logic err;
    logic [15:0] rdata;
    logic [7:0] wl, wh;
  } vec_t;

  function automatic vec_t mk(logic wr, logic byt, logic sgn, logic [15:0] addr, logic [15:0] wdata,
                              int lat, int ops, logic err, logic [15:0] rdata, logic [7:0] wl, logic [7:0] wh);
    vec_t v;
    v.wr = wr; v.byt = byt; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.ops = ops; v.err = err; v.rdata = rdata; v.wl = wl; v.wh = wh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string name);
    int lat = 0, ops = 0;
    logic [7:0] wl = 0, wh = 0;
    logic rdy_bad = 0, addr_bad = 0, err = 0;
    @(negedge clk);
    chk({name, " ready"}, req_ready, 1);
    req_valid = 1; req_wr = v.wr; req_byte = v.byt; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      if (req_ready) rdy_bad = 1;
      if (d_mem_opertn) begin
        ops++;
        if (d_mem_addr !== v.addr) addr_bad = 1;
        if (wr_rd) begin wl = d_mem_wr_data_l; wh = d_mem_wr_data_h; end
      end
      if (resp_valid) begin lat = c; err = resp_err; end
      else @(negedge clk);
    end
    chk({name, " latency"}, lat, v.lat);
    chk({name, " err"}, err, v.err);
    chk({name, " rdata"}, resp_rdata, v.rdata);
    chk({name, " mem ops"}, ops, v.ops);
    chk({name, " busy ready low"}, rdy_bad, 0);
    if (v.ops > 0) chk({name, " mem addr"}, addr_bad, 0);
    if (v.wr && !v.err) chk({name, " write bytes"}, {wh, wl}, {v.wh, v.wl});
    @(negedge clk);
    chk({name, " pulse ends"}, {resp_valid, req_ready}, 2'b01);
  endtask

  task automatic reset_mid(input int at_cycle, input string name);
    logic bad = 0;
    @(negedge clk);
    req_valid = 1; req_wr = 1; req_byte = 1; req_signed = 0; req_addr = 16'h0004; req_wdata = 16'h00AA;
    @(negedge clk);
    req_valid = 0;
    repeat (at_cycle - 1) @(negedge clk);
    if (at_cycle == 3) chk({name, " in WR"}, {d_mem_opertn, wr_rd}, 2'b11);
    reset = 0;
    #1 chk({name, " opertn forced low"}, d_mem_opertn, 0);
    @(negedge clk);
    chk({name, " idle after reset"}, {req_ready, busy, resp_valid, resp_err}, 4'b1000);
    chk({name, " rdata cleared"}, resp_rdata, 0);
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid || d_mem_opertn) bad = 1;
      @(negedge clk);
    end
    chk({name, " no response or access"}, bad, 0);
    run(mk(0, 0, 0, 16'h0004, 0, 3, 1, 0, 16'h3412, 0, 0), {name, " readback"});
  endtask

  vec_t vt[15];

  initial begin
    vt[0]  = mk(0, 0, 0, 16'h0000, 16'h0000, 3, 1, 0, 16'h0006, 8'h00, 8'h00);
    vt[1]  = mk(1, 0, 0, 16'h000A, 16'hBEEF, 2, 1, 0, 16'h0006, 8'hEF, 8'hBE);
    vt[2]  = mk(0, 0, 0, 16'h000A, 16'h0000, 3, 1, 0, 16'hBEEF, 8'h00, 8'h00);
    vt[3]  = mk(0, 1, 1, 16'h0008, 16'h0000, 3, 1, 0, 16'hFF84, 8'h00, 8'h00);
    vt[4]  = mk(0, 1, 0, 16'h0008, 16'h0000, 3, 1, 0, 16'h0084, 8'h00, 8'h00);
    vt[5]  = mk(1, 1, 0, 16'h0002, 16'h775A, 4, 2, 0, 16'h0084, 8'h5A, 8'h40);
    vt[6]  = mk(0, 0, 0, 16'h0002, 16'h0000, 3, 1, 0, 16'h405A, 8'h00, 8'h00);
    vt[7]  = mk(0, 0, 0, 16'h007F, 16'h0000, 1, 0, 1, 16'h405A, 8'h00, 8'h00);
    vt[8]  = mk(1, 1, 0, 16'hFFFF, 16'h1111, 1, 0, 1, 16'h405A, 8'h00, 8'h00);
    vt[9]  = mk(0, 0, 0, 16'h007E, 16'h0000, 3, 1, 0, 16'h11C3, 8'h00, 8'h00);
    vt[10] = mk(0, 1, 1, 16'h007E, 16'h0000, 3, 1, 0, 16'hFFC3, 8'h00, 8'h00);
    vt[11] = mk(1, 0, 0, 16'h0080, 16'h1234, 1, 0, 1, 16'hFFC3, 8'h00, 8'h00);
    vt[12] = mk(0, 1, 0, 16'h0003, 16'h0000, 3, 1, 0, 16'h0040, 8'h00, 8'h00);
    vt[13] = mk(1, 1, 1, 16'h0003, 16'h99F0, 4, 2, 0, 16'h0040, 8'hF0, 8'h12);
    vt[14] = mk(0, 0, 0, 16'h0002, 16'h0000, 3, 1, 0, 16'hF05A, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("reset outputs", {req_ready, busy, resp_valid, resp_err, d_mem_opertn}, 5'b10000);
    chk("reset rdata", resp_rdata, 0);
    reset = 1;
    @(negedge clk);
    chk("idle memory port", {d_mem_addr, wr_rd, d_mem_wr_data_l, d_mem_wr_data_h}, 0);
    for (int i = 0; i < 15; i++) run(vt[i], $sformatf("vec%0d", i));
    reset_mid(2, "reset in WAIT");
    reset_mid(3, "reset in WR");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
